// File: rtl/dp_pkg.sv
// dp_pkg: opcodes, widths and sequencer state encoding shared across the accumulator CPU.
package dp_pkg;
  localparam int ADR_W = 6;
  localparam int DAT_W = 8;
  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_STA = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;
  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_INC    = 4'd2,
    S_DECODE = 4'd3,
    S_LDA    = 4'd4,
    S_STA    = 4'd5,
    S_ADD    = 4'd6,
    S_JMP    = 4'd7,
    S_FAULT  = 4'd8
`ifdef DP_SEQUENCER_SINGLE_STEP_EN
    ,S_PAUSE = 4'd9
`endif
  } state_t;
endpackage

// File: rtl/dp_sequencer.sv
// dp_sequencer: Moore control FSM for the 8-bit accumulator datapath with memory wait timeout.
// Optional single-step pause after each instruction when DP_SEQUENCER_SINGLE_STEP_EN is defined.
module dp_sequencer
  import dp_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
`ifdef DP_SEQUENCER_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [1:0] op_code,
  input  logic       mem_ready,
  output logic       ir_on_adr,
  output logic       pc_on_adr,
  output logic       data_on_dbus,
  output logic       dbus_on_data,
  output logic       alu_on_dbus,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       clr_pc,
  output logic       pass,
  output logic       add,
  output logic       read_mem,
  output logic       write_mem,
  output logic       fault,
  output logic       busy
);
  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
`ifdef DP_SEQUENCER_SINGLE_STEP_EN
  localparam state_t S_DONE = S_PAUSE;
`else
  localparam state_t S_DONE = S_FETCH;
`endif
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic mem_st, tmo_hit;
  always_comb begin
    mem_st = state_q inside {S_FETCH, S_LDA, S_STA, S_ADD};
    tmo_hit = TMO != 8'd0 && cnt_q == TMO;
    state_d = S_RESET;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_INC : tmo_hit ? S_FAULT : S_FETCH;
      S_INC:    state_d = S_DECODE;
      S_DECODE: state_d = op_code == OP_LDA ? S_LDA :
                          op_code == OP_STA ? S_STA :
                          op_code == OP_ADD ? S_ADD : S_JMP;
      S_LDA, S_STA, S_ADD: state_d = mem_ready ? S_DONE : tmo_hit ? S_FAULT : state_q;
      S_JMP:    state_d = S_DONE;
      S_FAULT:  state_d = S_FAULT;
`ifdef DP_SEQUENCER_SINGLE_STEP_EN
      S_PAUSE:  state_d = step ? S_FETCH : S_PAUSE;
`endif
      default:  state_d = S_RESET;
    endcase
    if (reset) state_d = S_RESET;
    // counter only survives while we stay in the same memory state still waiting
    cnt_d = (!reset && mem_st && !mem_ready && state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign clr_pc       = state_q == S_RESET;
  assign pc_on_adr    = state_q == S_FETCH;
  assign ld_ir        = state_q == S_FETCH;
  assign inc_pc       = state_q == S_INC;
  assign ir_on_adr    = state_q inside {S_LDA, S_STA, S_ADD, S_JMP};
  assign read_mem     = state_q inside {S_FETCH, S_LDA, S_ADD};
  assign data_on_dbus = state_q inside {S_FETCH, S_LDA, S_ADD};
  assign ld_ac        = state_q inside {S_LDA, S_ADD};
  assign pass         = state_q inside {S_LDA, S_STA};
  assign add          = state_q == S_ADD;
  assign alu_on_dbus  = state_q == S_STA;
  assign dbus_on_data = state_q == S_STA;
  assign write_mem    = state_q == S_STA;
  assign ld_pc        = state_q == S_JMP;
  assign fault        = state_q == S_FAULT;
  assign busy         = state_q inside {S_FETCH, S_INC, S_DECODE, S_LDA, S_STA, S_ADD, S_JMP};
endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: directed vector tables plus randomized instruction streams for dp_sequencer.
module tb_dp_sequencer;
  localparam int TMO = 4;
  localparam logic [15:0] B_IR = 16'h8000, B_PC = 16'h4000, B_DD = 16'h2000, B_DBD = 16'h1000;
  localparam logic [15:0] B_ALU = 16'h0800, B_LIR = 16'h0400, B_LAC = 16'h0200, B_LPC = 16'h0100;
  localparam logic [15:0] B_INC = 16'h0080, B_CLR = 16'h0040, B_PASS = 16'h0020, B_ADD = 16'h0010;
  localparam logic [15:0] B_RD = 16'h0008, B_WR = 16'h0004, B_FLT = 16'h0002, B_BUSY = 16'h0001;
  localparam logic [15:0] V_RESET = B_CLR;
  localparam logic [15:0] V_FETCH = B_PC | B_RD | B_DD | B_LIR | B_BUSY;
  localparam logic [15:0] V_INC   = B_INC | B_BUSY;
  localparam logic [15:0] V_DEC   = B_BUSY;
  localparam logic [15:0] V_LDA   = B_IR | B_RD | B_DD | B_PASS | B_LAC | B_BUSY;
  localparam logic [15:0] V_STA   = B_IR | B_PASS | B_ALU | B_DBD | B_WR | B_BUSY;
  localparam logic [15:0] V_ADD   = B_IR | B_RD | B_DD | B_ADD | B_LAC | B_BUSY;
  localparam logic [15:0] V_JMP   = B_IR | B_LPC | B_BUSY;
  localparam logic [15:0] V_FAULT = B_FLT;
  localparam logic [15:0] V_PAUSE = 16'h0000;
`ifdef DP_SEQUENCER_SINGLE_STEP_EN
  localparam logic [15:0] V_AFT = V_PAUSE;
`else
  localparam logic [15:0] V_AFT = V_FETCH;
`endif
  typedef struct {
    logic rst; logic [1:0] op; logic rdy; logic stp; logic chk; logic [15:0] exp; string nm;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic [1:0] op_code = 2'b00;
`ifdef DP_SEQUENCER_SINGLE_STEP_EN
  logic step = 1'b0;
`endif
  logic ir_on_adr, pc_on_adr, data_on_dbus, dbus_on_data, alu_on_dbus, ld_ir, ld_ac, ld_pc;
  logic inc_pc, clr_pc, pass, add, read_mem, write_mem, fault, busy;
  logic [15:0] got;
  int n_run = 0, n_fail = 0;
  vec_t q[$];

  dp_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
`ifdef DP_SEQUENCER_SINGLE_STEP_EN
    .step(step),
`endif
    .op_code(op_code), .mem_ready(mem_ready),
    .ir_on_adr(ir_on_adr), .pc_on_adr(pc_on_adr), .data_on_dbus(data_on_dbus),
    .dbus_on_data(dbus_on_data), .alu_on_dbus(alu_on_dbus), .ld_ir(ld_ir), .ld_ac(ld_ac),
    .ld_pc(ld_pc), .inc_pc(inc_pc), .clr_pc(clr_pc), .pass(pass), .add(add),
    .read_mem(read_mem), .write_mem(write_mem), .fault(fault), .busy(busy)
  );

  assign got = {ir_on_adr, pc_on_adr, data_on_dbus, dbus_on_data, alu_on_dbus, ld_ir, ld_ac,
                ld_pc, inc_pc, clr_pc, pass, add, read_mem, write_mem, fault, busy};

  always #5 clk = ~clk;

  task automatic push(input logic rst, input logic [1:0] op, input logic rdy, input logic stp,
                      input logic chk, input logic [15:0] exp, input string nm);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.stp = stp; v.chk = chk; v.exp = exp; v.nm = nm;
    q.push_back(v);
  endtask

  task automatic cyc(input logic [1:0] op, input logic rdy, input logic [15:0] exp, input string nm);
    push(1'b0, op, rdy, 1'b0, 1'b1, exp, nm);
  endtask

  task automatic start(input string nm);
    push(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, nm);
    cyc(2'($urandom), 1'($urandom), V_RESET, {nm, "_reset"});
  endtask

  // a memory access answered after w wait cycles
  task automatic access(input logic [15:0] exp, input int w, input string nm);
    for (int i = 0; i <= w; i++) cyc(2'($urandom), i == w, exp, nm);
  endtask

  task automatic run();
    while (q.size() > 0) begin
      vec_t v;
      v = q.pop_front();
      @(negedge clk);
      reset = v.rst; op_code = v.op; mem_ready = v.rdy;
`ifdef DP_SEQUENCER_SINGLE_STEP_EN
      step = v.stp;
`endif
      if (v.chk) begin
        n_run++;
        if (got !== v.exp) begin
          n_fail++;
          $display("FAIL %s: outputs got %h expected %h at %0t", v.nm, got, v.exp, $time);
        end
        n_run++;
        if ((got[5] && got[4]) || (got[15] && got[14]) || (got[3] && got[2])) begin
          n_fail++;
          $display("FAIL %s_exclusive: outputs got %h violate pass/add, adr or rd/wr exclusivity", v.nm, got);
        end
      end
    end
  endtask

  task automatic rnd_instr();
    logic [1:0] op;
    op = 2'($urandom_range(0, 3));
    access(V_FETCH, $urandom_range(0, TMO), "rnd_fetch");
    cyc(2'($urandom), 1'($urandom), V_INC, "rnd_inc");
    cyc(op, 1'($urandom), V_DEC, "rnd_dec");
    case (op)
      2'b00: access(V_LDA, $urandom_range(0, TMO), "rnd_lda");
      2'b01: access(V_STA, $urandom_range(0, TMO), "rnd_sta");
      2'b10: access(V_ADD, $urandom_range(0, TMO), "rnd_add");
      default: cyc(2'($urandom), 1'($urandom), V_JMP, "rnd_jmp");
    endcase
`ifdef DP_SEQUENCER_SINGLE_STEP_EN
    for (int k = $urandom_range(0, 3); k > 0; k--)
      push(1'b0, 2'($urandom), 1'($urandom), 1'b0, 1'b1, V_PAUSE, "rnd_pause");
    push(1'b0, 2'($urandom), 1'($urandom), 1'b1, 1'b1, V_PAUSE, "rnd_step");
`endif
  endtask

  initial begin
    start("lda");
    cyc(2'b00, 1'b1, V_FETCH, "lda_fetch");
    cyc(2'b00, 1'b1, V_INC, "lda_inc");
    cyc(2'b00, 1'b1, V_DEC, "lda_dec");
    cyc(2'b00, 1'b1, V_LDA, "lda_exec");
    cyc(2'b00, 1'b1, V_AFT, "lda_after");
`ifdef DP_SEQUENCER_SINGLE_STEP_EN
    for (int i = 0; i < 10; i++) push(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, V_PAUSE, "pause_idle");
    push(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, V_PAUSE, "pause_step");
    cyc(2'b00, 1'b1, V_FETCH, "pause_fetch");
`endif
    start("jmp");
    cyc(2'b11, 1'b1, V_FETCH, "jmp_fetch");
    cyc(2'b11, 1'b1, V_INC, "jmp_inc");
    cyc(2'b11, 1'b1, V_DEC, "jmp_dec");
    cyc(2'b11, 1'b0, V_JMP, "jmp_exec");
    cyc(2'b11, 1'b0, V_AFT, "jmp_after");
    start("sta");
    cyc(2'b01, 1'b1, V_FETCH, "sta_fetch");
    cyc(2'b01, 1'b1, V_INC, "sta_inc");
    cyc(2'b01, 1'b1, V_DEC, "sta_dec");
    access(V_STA, 3, "sta_wait");
    cyc(2'b01, 1'b1, V_AFT, "sta_after");
    start("tmo");
    access(V_FETCH, TMO + 1, "tmo_fetch");
    void'(q.pop_back());
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b1, V_FAULT, "tmo_fault");
    push(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, V_FAULT, "tmo_rst_edge");
    cyc(2'b00, 1'b1, V_RESET, "tmo_clear");
    cyc(2'b00, 1'b1, V_FETCH, "tmo_refetch");
    start("addlim");
    cyc(2'b10, 1'b1, V_FETCH, "addlim_fetch");
    cyc(2'b10, 1'b1, V_INC, "addlim_inc");
    cyc(2'b10, 1'b1, V_DEC, "addlim_dec");
    access(V_ADD, TMO, "addlim_wait");
    cyc(2'b10, 1'b1, V_AFT, "addlim_after");
    start("midrst");
    cyc(2'b01, 1'b1, V_FETCH, "midrst_fetch");
    cyc(2'b01, 1'b1, V_INC, "midrst_inc");
    cyc(2'b01, 1'b1, V_DEC, "midrst_dec");
    cyc(2'b01, 1'b0, V_STA, "midrst_wait");
    cyc(2'b01, 1'b0, V_STA, "midrst_wait");
    push(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, V_STA, "midrst_edge");
    cyc(2'b01, 1'b0, V_RESET, "midrst_reset");
    access(V_FETCH, TMO, "midrst_cleared");
    cyc(2'b01, 1'b0, V_INC, "midrst_inc2");
    run();
    start("rnd");
    for (int n = 0; n < 200; n++) rnd_instr();
    run();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
